// File: rtl/pirdsp_result_accumulator.sv
// Receive-side accumulator for the PIRDSP multiplier: resolves the redundant
// result pair into per-lane products and sums a block of beats per lane.
module pirdsp_result_accumulator #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_r0,
  input  logic [31:0]      in_r1,
  input  logic [3:0]       in_carry,
  input  logic [1:0]       in_mode,
  input  logic             in_signed,
  input  logic [CNT_W-1:0] acc_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [1:0]       out_mode,
  output logic [3:0]       out_ovf
);

  localparam int L1 = ACC_W / 2;
  localparam int L2 = ACC_W / 4;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic [CNT_W-1:0] eff_len;
  logic [CNT_W-1:0] blk_len;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       blk_mode;
  logic             blk_signed;
  logic [1:0]       cur_mode;
  logic             cur_signed;

  logic             s1_valid;
  logic             s1_first;
  logic [ACC_W-1:0] s1_v;
  logic [ACC_W-1:0] res_v;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [3:0]       ovf, ovf_nxt;

  logic [31:0]      sum32;
  logic [16:0]      sum17 [2];
  logic [8:0]       sum9  [4];
  logic [ACC_W:0]   add0;
  logic [L1:0]      add1  [2];
  logic [L2:0]      add2  [4];

  assign accept  = in_valid && in_ready;
  assign eff_len = (acc_len == '0) ? CNT_W'(1) : acc_len;

  // The first beat of a block uses the live mode/sign; later beats use the latched copy.
  assign cur_mode   = (state == IDLE) ? in_mode   : blk_mode;
  assign cur_signed = (state == IDLE) ? in_signed : blk_signed;

  function automatic logic lane_ovf(input logic sgn, input logic a_msb, input logic b_msb,
                                    input logic s_msb, input logic cout);
    return sgn ? ((a_msb == b_msb) && (s_msb != a_msb)) : cout;
  endfunction

  always_comb begin
    res_v = '0;
    sum32 = in_r0 + in_r1;
    for (int k = 0; k < 2; k++)
      sum17[k] = {1'b0, in_r0[16*k +: 16]} + {1'b0, in_r1[16*k +: 16]} + {in_carry[2*k+1], 16'h0000};
    for (int k = 0; k < 4; k++)
      sum9[k] = {1'b0, in_r0[8*k +: 8]} + {1'b0, in_r1[8*k +: 8]} + {in_carry[k], 8'h00};
    case (cur_mode)
      2'b00: res_v = cur_signed ? ACC_W'($signed(sum32)) : ACC_W'(sum32);
      2'b01: begin
        for (int k = 0; k < 2; k++)
          res_v[k*L1 +: L1] = cur_signed ? L1'($signed(sum17[k])) : L1'(sum17[k]);
      end
      default: begin
        for (int k = 0; k < 4; k++)
          res_v[k*L2 +: L2] = cur_signed ? L2'($signed(sum9[k])) : L2'(sum9[k]);
      end
    endcase
  end

  // Lane-partitioned add: each lane has its own adder so no carry crosses lanes.
  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf;
    add0 = {1'b0, acc} + {1'b0, s1_v};
    for (int k = 0; k < 2; k++)
      add1[k] = {1'b0, acc[k*L1 +: L1]} + {1'b0, s1_v[k*L1 +: L1]};
    for (int k = 0; k < 4; k++)
      add2[k] = {1'b0, acc[k*L2 +: L2]} + {1'b0, s1_v[k*L2 +: L2]};
    if (s1_first) begin
      acc_nxt = s1_v;
      ovf_nxt = '0;
    end else begin
      case (blk_mode)
        2'b00: begin
          acc_nxt    = add0[ACC_W-1:0];
          ovf_nxt[0] = ovf[0] | lane_ovf(blk_signed, acc[ACC_W-1], s1_v[ACC_W-1],
                                         add0[ACC_W-1], add0[ACC_W]);
        end
        2'b01: begin
          for (int k = 0; k < 2; k++) begin
            acc_nxt[k*L1 +: L1] = add1[k][L1-1:0];
            ovf_nxt[k] = ovf[k] | lane_ovf(blk_signed, acc[k*L1+L1-1], s1_v[k*L1+L1-1],
                                           add1[k][L1-1], add1[k][L1]);
          end
        end
        default: begin
          for (int k = 0; k < 4; k++) begin
            acc_nxt[k*L2 +: L2] = add2[k][L2-1:0];
            ovf_nxt[k] = ovf[k] | lane_ovf(blk_signed, acc[k*L2+L2-1], s1_v[k*L2+L2-1],
                                           add2[k][L2-1], add2[k][L2]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // DRAIN waits until stage 2 has absorbed the last beat before presenting the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (eff_len == CNT_W'(1)) ? DRAIN : ACC;
      ACC:     if (accept && ((cnt + CNT_W'(1)) == blk_len)) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_v       <= '0;
      blk_mode   <= 2'b00;
      blk_signed <= 1'b0;
      blk_len    <= '0;
      cnt        <= '0;
      acc        <= '0;
      ovf        <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_v     <= res_v;
        s1_first <= (state == IDLE);
        if (state == IDLE) begin
          blk_mode   <= in_mode;
          blk_signed <= in_signed;
          blk_len    <= eff_len;
          cnt        <= CNT_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (s1_valid) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
      end
    end
  end

  assign in_ready  = !reset && ((state == IDLE) || (state == ACC));
  assign out_valid = (state == HOLD);
  assign out_acc   = acc;
  assign out_mode  = blk_mode;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_pirdsp_result_accumulator.sv
// Scoreboard bench for pirdsp_result_accumulator: blocks are issued with their
// expected result queued; a monitor pops and compares on every output handshake.
module tb_pirdsp_result_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_r0, in_r1;
  logic [3:0]  in_carry;
  logic [1:0]  in_mode;
  logic        in_signed;
  logic [7:0]  acc_len;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_acc;
  logic [1:0]  out_mode;
  logic [3:0]  out_ovf;

  typedef struct {
    logic [47:0] acc;
    logic [1:0]  mode;
    logic [3:0]  ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] beat_r0[$];
  logic [31:0] beat_r1[$];
  logic [3:0]  beat_c[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int rdy_mode = 0;

  pirdsp_result_accumulator dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r0(in_r0), .in_r1(in_r1), .in_carry(in_carry),
    .in_mode(in_mode), .in_signed(in_signed), .acc_len(acc_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_mode(out_mode), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    n_total++;
    n_bad++;
    $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Lane product before lane-width reduction, as a signed/unsigned integer.
  function automatic longint lane_val(input int em, input bit s, input logic [31:0] r0,
                                      input logic [31:0] r1, input logic [3:0] c, input int k);
    longint raw;
    int bits;
    if (em == 0) begin
      raw  = (longint'(r0) + longint'(r1)) % (longint'(1) << 32);
      bits = 32;
    end else if (em == 1) begin
      raw  = (longint'((r0 >> (16*k)) & 32'hFFFF) + longint'((r1 >> (16*k)) & 32'hFFFF)
             + (c[2*k+1] ? 65536 : 0)) % 131072;
      bits = 17;
    end else begin
      raw  = (longint'((r0 >> (8*k)) & 32'hFF) + longint'((r1 >> (8*k)) & 32'hFF)
             + (c[k] ? 256 : 0)) % 512;
      bits = 9;
    end
    if (s && raw >= (longint'(1) << (bits-1))) raw = raw - (longint'(1) << bits);
    return raw;
  endfunction

  function automatic exp_t model(input logic [1:0] m, input bit s, input int nb);
    exp_t e;
    int em, nl, lw;
    longint lm, v, vu, sum, as_v, ex;
    longint acc[4];
    em = (m == 2'b11) ? 2 : int'(m);
    nl = (em == 0) ? 1 : (em == 1) ? 2 : 4;
    lw = 48 / nl;
    lm = longint'(1) << lw;
    e.acc = '0;
    e.ovf = '0;
    e.mode = m;
    for (int k = 0; k < 4; k++) acc[k] = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < nl; k++) begin
        v  = lane_val(em, s, beat_r0[b], beat_r1[b], beat_c[b], k);
        vu = ((v % lm) + lm) % lm;
        if (b == 0) begin
          acc[k] = vu;
        end else begin
          sum = acc[k] + vu;
          if (!s) begin
            if (sum >= lm) e.ovf[k] = 1'b1;
          end else begin
            as_v = (acc[k] >= lm/2) ? acc[k] - lm : acc[k];
            ex   = as_v + v;
            if (ex >= lm/2 || ex < -(lm/2)) e.ovf[k] = 1'b1;
          end
          acc[k] = sum % lm;
        end
      end
    end
    for (int k = 0; k < nl; k++) e.acc = e.acc | (48'(acc[k]) << (k*lw));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("[TB] FAIL unexpected_result: got acc 0x%0h with empty scoreboard", out_acc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_acc", 64'(out_acc), 64'(e.acc));
        checkOutput("out_mode", 64'(out_mode), 64'(e.mode));
        checkOutput("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic fill_const(input logic [31:0] r0, input logic [31:0] r1, input logic [3:0] c,
                            input int n);
    beat_r0.delete(); beat_r1.delete(); beat_c.delete();
    for (int i = 0; i < n; i++) begin
      beat_r0.push_back(r0); beat_r1.push_back(r1); beat_c.push_back(c);
    end
  endtask

  task automatic fill_rand(input int n);
    beat_r0.delete(); beat_r1.delete(); beat_c.delete();
    for (int i = 0; i < n; i++) begin
      beat_r0.push_back($urandom); beat_r1.push_back($urandom); beat_c.push_back(4'($urandom));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the edge that took the beat.
  task automatic send_beat(input logic [31:0] r0, input logic [31:0] r1, input logic [3:0] c,
                           input logic [1:0] m, input bit s, input logic [7:0] len,
                           output int acc_cyc);
    bit got;
    int guard;
    in_valid = 1'b1; in_r0 = r0; in_r1 = r1; in_carry = c;
    in_mode = m; in_signed = s; acc_len = len;
    got = 1'b0;
    guard = 0;
    while (!got) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!got && guard > 500) begin
        failNow("beat_accept");
        break;
      end
    end
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input bit s, input logic [7:0] len,
                               input bit gaps, input bit have_exp, input exp_t fixed,
                               output int last_cyc);
    int nb;
    nb = (len == 0) ? 1 : int'(len);
    exp_q.push_back(have_exp ? fixed : model(m, s, nb));
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_r0 = $urandom;
        @(posedge clk);
        #1;
      end
      if (b == 0)
        send_beat(beat_r0[b], beat_r1[b], beat_c[b], m, s, len, last_cyc);
      else
        send_beat(beat_r0[b], beat_r1[b], beat_c[b], 2'($urandom), 1'($urandom),
                  8'($urandom), last_cyc);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      failNow("result_drain");
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    int t, h, g, len, nb;
    logic [1:0] m;
    bit s;

    reset = 1'b1; in_valid = 1'b0; in_r0 = '0; in_r1 = '0; in_carry = '0;
    in_mode = '0; in_signed = 1'b0; acc_len = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("rst_out_mode", 64'(out_mode), 64'd0);
    checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Mode 00 unsigned, three back-to-back beats, with latency check.
    fill_const(32'h0000_0064, 32'h0, 4'h0, 3);
    e.acc = 48'h00_0000_012C; e.mode = 2'b00; e.ovf = 4'h0;
    applyStimulus(2'b00, 1'b0, 8'd3, 1'b0, 1'b1, e, t);
    @(negedge clk);
    checkOutput("lat_t0_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lat_t1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lat_t2_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    wait_drain();

    // Mode 00 signed: -100 + -100.
    fill_const(32'hFFFF_FF9C, 32'h0, 4'h0, 2);
    e.acc = 48'hFFFF_FFFF_FF38; e.mode = 2'b00; e.ovf = 4'h0;
    applyStimulus(2'b00, 1'b1, 8'd2, 1'b0, 1'b1, e, t);
    wait_drain();

    // Mode 01 unsigned single beat: both lanes resolve to 0x10000.
    fill_const(32'h8000_FFFF, 32'h8000_0001, 4'h0, 1);
    e.acc = 48'h010000_010000; e.mode = 2'b01; e.ovf = 4'h0;
    applyStimulus(2'b01, 1'b0, 8'd1, 1'b0, 1'b1, e, t);
    wait_drain();

    // Mode 10, 16 beats of 0x100 per lane with idle gaps: every lane wraps.
    fill_const(32'hFFFF_FFFF, 32'h0101_0101, 4'h0, 16);
    e.acc = 48'h0; e.mode = 2'b10; e.ovf = 4'hF;
    applyStimulus(2'b10, 1'b0, 8'd16, 1'b1, 1'b1, e, t);
    wait_drain();

    // Backpressure: result held while input is offered; next block starts right after.
    rdy_mode = 2;
    out_ready = 1'b0;
    fill_const(32'h0000_1234, 32'h0000_0010, 4'h0, 1);
    e.acc = 48'h1244; e.mode = 2'b00; e.ovf = 4'h0;
    applyStimulus(2'b00, 1'b0, 8'd1, 1'b0, 1'b1, e, t);
    g = 0;
    while (out_valid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (out_valid !== 1'b1) failNow("bp_out_valid");
    @(posedge clk); #1;
    e.acc = 48'h9; e.mode = 2'b00; e.ovf = 4'h0;
    exp_q.push_back(e);
    in_valid = 1'b1; in_r0 = 32'h9; in_r1 = 32'h0; in_carry = 4'h0;
    in_mode = 2'b00; in_signed = 1'b0; acc_len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_out_acc", 64'(out_acc), 64'h1244);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    h = cyc;
    rdy_mode = 0;
    @(negedge clk);
    checkOutput("bp_after_h_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_after_h_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_block_started", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    wait_drain();

    // Mid-block reset discards partial sums.
    send_beat(32'h1234_5678, 32'h1111_1111, 4'hA, 2'b01, 1'b1, 8'd4, t);
    send_beat(32'h0F0F_0F0F, 32'h2222_2222, 4'h5, 2'b01, 1'b1, 8'd4, t);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mrst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("mrst_out_mode", 64'(out_mode), 64'd0);
    checkOutput("mrst_out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("mrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    fill_const(32'h5, 32'h0, 4'h0, 1);
    e.acc = 48'h5; e.mode = 2'b00; e.ovf = 4'h0;
    applyStimulus(2'b00, 1'b0, 8'd0, 1'b0, 1'b1, e, t);
    wait_drain();

    // Randomized blocks against the reference model, with random output stalls.
    rdy_mode = 1;
    for (int blk = 0; blk < 40; blk++) begin
      m   = 2'($urandom);
      s   = 1'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 6));
      nb  = (len == 0) ? 1 : len;
      fill_rand(nb);
      applyStimulus(m, s, 8'(len), 1'($urandom), 1'b0, e, t);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pirdsp_result_accumulator.md
# pirdsp_result_accumulator

Receive-side companion of the PIRDSP precision-configurable multiplier. It accepts the multiplier's redundant result pair (`result_0`/`result_1` plus the per-lane SIMD carry bits) with a valid/ready handshake. It resolves the pair into per-lane products according to the precision mode, then accumulates a programmable number of beats into lane-partitioned accumulators. It sits directly downstream of the multiplier's output register and presents finished dot-product sums to the PE writeback stage.

## Interface
- `ACC_W`, default 48: total accumulator width.
  - Must be a multiple of 4 and ≥ 36.
  - Lane width LW = ACC_W (mode 00), ACC_W/2 (mode 01), ACC_W/4 (mode 10).
- `CNT_W`, default 8: width of the beat-count input.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset; synchronous, active-high; clock `clk`.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: block can accept a beat.
- `in_r0`, in, 32: result_0 word from the multiplier.
- `in_r1`, in, 32: result_1 word from the multiplier.
- `in_carry`, in, 4: SIMD carry bits.
- `in_mode`, in, 2: precision mode. 00 = 16x16, 01 = sum of 8x8, 10 = sum of 4x4, 11 = reserved (treated as 10).
- `in_signed`, in, 1: operands signed (a_sign|b_sign).
- `acc_len`, in, CNT_W: number of beats per block; 0 is treated as 1.
- `out_valid`, out, 1: accumulated block result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_acc`, out, ACC_W: lane k occupies bits [k·LW+LW−1 : k·LW].
- `out_mode`, out, 2: mode of the block, as latched.
- `out_ovf`, out, 4: sticky per-lane overflow; bits of unused lanes are 0.

## Operation
- A block starts with the first beat accepted in IDLE.
  - `in_mode`, `in_signed` and `acc_len` are latched on that beat.
  - The same inputs on later beats of the block are ignored.
- Stage 1 (registered) resolves the lane values:
  - Mode 00: one lane. V = (in_r0 + in_r1) mod 2^32. Sign-extended from bit 31 if signed, else zero-extended to LW.
  - Mode 01: lanes k = 0, 1. V = ({0, r0[16k+15:16k]} + {0, r1[16k+15:16k]} + (carry[2k+1] << 16)) mod 2^17. No carry crosses lanes. Extended from bit 16.
  - Mode 10: lanes k = 0..3. V = ({0, r0 byte k} + {0, r1 byte k} + (carry[k] << 8)) mod 2^9. Extended from bit 8.
- Stage 2 (registered) updates the accumulators:
  - On the first beat of a block, acc_lane = V.
  - On later beats, acc_lane = (acc_lane + V) mod 2^LW. No carry crosses lanes.
- `out_ovf[k]` is sticky per block and cleared on the first beat. It is set when either of these occurs on a lane-k add:
  - Unsigned: carry-out of lane k.
  - Signed: two's-complement overflow of lane k.
- Block state registers:
  - A beat counter counts accepted beats.
  - A pipeline-valid bit marks stage 1 as occupied.
- FSM states:
  - IDLE: no block in progress; `in_ready` = 1.
  - ACC: block in progress, beats remaining; `in_ready` = 1.
  - DRAIN: last beat is in stage 1; `in_ready` = 0.
  - HOLD: `out_valid` = 1; `in_ready` = 0; outputs stable.
- FSM transitions:
  - IDLE → ACC when a beat is accepted and acc_len > 1.
  - IDLE → DRAIN when a beat is accepted and the effective acc_len = 1.
  - ACC → DRAIN when the accepted beat brings the count to acc_len.
  - DRAIN → HOLD on the next cycle.
  - HOLD → IDLE when out_valid && out_ready.
- Idle cycles (`in_valid` = 0) inside ACC do not advance the count and do not modify the accumulators.

## Timing
- Reset values: state IDLE, `in_ready` = 0 during reset and 1 on the first cycle after. `out_valid` = 0, `out_acc` = 0, `out_mode` = 00, `out_ovf` = 0, count = 0, stage-1 valid = 0.
- Handshake:
  - A beat transfers on a rising edge with in_valid && in_ready.
  - A result transfers on a rising edge with out_valid && out_ready.
- Latency: last beat accepted at edge t → `out_valid` asserted after edge t+2.
- Throughput within a block is one beat per cycle.
- The output handshake at edge h returns the FSM to IDLE. `in_ready` = 1 after edge h, so the next block can start at edge h+1.
- In HOLD, `out_acc`, `out_mode` and `out_ovf` are held stable until the output handshake, regardless of `out_ready` stalls or input activity.
- `reset` asserted in any state aborts the block on that edge. All outputs take their reset values; partial sums are discarded.
- If `in_mode` changes mid-block, it has no effect.

## Test plan
- Mode 00, unsigned, acc_len = 3: three beats of r0 = 0x0000_0064, r1 = 0, back to back → `out_acc` = 0x00_0000_012C, `out_ovf` = 0, `out_valid` 2 cycles after the third beat.
- Mode 00, signed, acc_len = 2: two beats of r0 = 0xFFFF_FF9C, r1 = 0 → `out_acc` = 0xFFFF_FFFF_FF38 (−200), `out_ovf` = 0.
- Mode 01, unsigned, acc_len = 1: r0 = 0x8000_FFFF, r1 = 0x8000_0001, carry = 0 → lane 0 = 0x10000, lane 1 = 0x10000. `out_acc` = 0x010000_010000.
- Mode 10, unsigned, acc_len = 16: every beat has r0 = 0xFFFF_FFFF, r1 = 0x0101_0101, carry = 0; each lane gets V = 0x100. Result → every 12-bit lane wraps to 0x000 and `out_ovf` = 4'hF.
- Backpressure: complete a block, hold `out_ready` = 0 for 5 cycles while driving `in_valid` = 1 → `out_acc` stays stable and `in_ready` = 0 throughout. On the handshake, the next block starts one cycle later.
- Mid-block reset: acc_len = 4, `reset` asserted after 2 beats → all outputs are 0 and IDLE is entered. A fresh single-beat block in mode 00 with r0 = 5, r1 = 0 (acc_len = 0, treated as 1) → `out_acc` = 5.
